// File: rtl/core_pkg.sv
// Shared definitions for the RV32I load/store path.
// Holds funct3 encodings, response codes, LSU states and AXI constants.
package core_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS      = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    localparam logic [1:0] BURST_INCR      = 2'b01;
    localparam int         RESP_SLVERR_BIT = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WADDR = 3'd3,
        S_WRESP = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
        if (write)
            return !(f3 == F3_SB || f3 == F3_SH || f3 == F3_SW);
        return !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LW ||
                 f3 == F3_LBU || f3 == F3_LHU);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'd1:    return a[0];
            2'd2:    return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data bus: store replication/strobes and
// load extraction. Ports: funct3_i, lane_i, wdata_i, rdata_i -> wdata_o, wstrb_o, rdata_o.
module mem_lane_align
    import core_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]                 funct3_i,
    input  logic [$clog2(DW/8)-1:0]    lane_i,
    input  logic [31:0]                wdata_i,
    input  logic [DW-1:0]              rdata_i,
    output logic [DW-1:0]              wdata_o,
    output logic [DW/8-1:0]            wstrb_o,
    output logic [31:0]                rdata_o
);

    localparam int NB = DW / 8;

    logic [NB-1:0] mask;
    logic [31:0]   shifted;

    always_comb begin
        wdata_o = {(DW/32){wdata_i}};
        mask    = NB'(15);
        case (funct3_i[1:0])
            2'd0: begin
                wdata_o = {NB{wdata_i[7:0]}};
                mask    = NB'(1);
            end
            2'd1: begin
                wdata_o = {(DW/16){wdata_i[15:0]}};
                mask    = NB'(3);
            end
            default: ;
        endcase
        wstrb_o = mask << lane_i;

        // Bring the addressed lane down to bit 0 before sizing.
        shifted = 32'(rdata_i >> {lane_i, 3'b000});
        case (funct3_i)
            F3_LB:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  rdata_o = {24'd0, shifted[7:0]};
            F3_LHU:  rdata_o = {16'd0, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_access.sv
// Load/store unit: one core memory request -> one single-beat AXI4 access.
// Ports: REQ_*/MEM_WAIT/RESP_* toward the core, M_AXI_* master toward the bus.
module data_mem_access
    import core_pkg::*;
#(
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 32
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               REQ_VALID,
    input  logic                               REQ_WRITE,
    input  logic [2:0]                         REQ_FUNCT3,
    input  logic [31:0]                        REQ_ADDR,
    input  logic [31:0]                        REQ_WDATA,
    output logic                               MEM_WAIT,
    output logic                               RESP_VALID,
    output logic [31:0]                        RESP_RDATA,
    output logic [1:0]                         RESP_ERR,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
    output logic [7:0]                         M_AXI_AWLEN,
    output logic [2:0]                         M_AXI_AWSIZE,
    output logic [1:0]                         M_AXI_AWBURST,
    output logic                               M_AXI_AWVALID,
    input  logic                               M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
    output logic                               M_AXI_WLAST,
    output logic                               M_AXI_WVALID,
    input  logic                               M_AXI_WREADY,
    input  logic [1:0]                         M_AXI_BRESP,
    input  logic                               M_AXI_BVALID,
    output logic                               M_AXI_BREADY,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [7:0]                         M_AXI_ARLEN,
    output logic [2:0]                         M_AXI_ARSIZE,
    output logic [1:0]                         M_AXI_ARBURST,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RLAST,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY
);

    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam int LW = $clog2(NB);
    localparam int AW = C_M_AXI_ADDR_WIDTH;

    state_e        state_q;
    logic          arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic          resp_valid_q;
    logic [31:0]   resp_rdata_q;
    logic [1:0]    resp_err_q;
    logic [31:0]   addr_q;
    logic [2:0]    funct3_q;
    logic [DW-1:0] wdata_q;
    logic [NB-1:0] wstrb_q;

    logic          idle;
    logic [2:0]    al_f3;
    logic [LW-1:0] al_lane;
    logic [DW-1:0] al_wdata;
    logic [NB-1:0] al_wstrb;
    logic [31:0]   al_rdata;
    logic          req_illegal, req_misaligned;
    logic          aw_done, w_done;
    logic          unused_resp_lsb;

    assign idle = (state_q == S_IDLE);

    // In IDLE the aligner sees the live request (store lanes are
    // registered on accept); afterwards it sees the held request.
    assign al_f3   = idle ? REQ_FUNCT3 : funct3_q;
    assign al_lane = idle ? REQ_ADDR[LW-1:0] : addr_q[LW-1:0];

    mem_lane_align #(.DW(DW)) u_align (
        .funct3_i (al_f3),
        .lane_i   (al_lane),
        .wdata_i  (REQ_WDATA),
        .rdata_i  (M_AXI_RDATA),
        .wdata_o  (al_wdata),
        .wstrb_o  (al_wstrb),
        .rdata_o  (al_rdata)
    );

    assign req_illegal    = f3_illegal(REQ_WRITE, REQ_FUNCT3);
    assign req_misaligned = f3_misaligned(REQ_FUNCT3, REQ_ADDR[1:0]);

    // A channel counts as done if it already handshook or does so now.
    assign aw_done = !awvalid_q || M_AXI_AWREADY;
    assign w_done  = !wvalid_q  || M_AXI_WREADY;

    assign unused_resp_lsb = M_AXI_RRESP[0] ^ M_AXI_BRESP[0] ^ M_AXI_RLAST;

    // Stall rises with the request itself, before the FSM leaves IDLE.
    assign MEM_WAIT = !RST && ((idle && REQ_VALID) ||
                               (!idle && state_q != S_DONE));

    assign RESP_VALID    = resp_valid_q;
    assign RESP_RDATA    = resp_rdata_q;
    assign RESP_ERR      = resp_err_q;
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = AW'(addr_q);
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = {1'b0, funct3_q[1:0]};
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WLAST   = 1'b1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = AW'(addr_q);
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = {1'b0, funct3_q[1:0]};
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_OK;
            addr_q       <= '0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: if (REQ_VALID) begin
                    addr_q   <= REQ_ADDR;
                    funct3_q <= REQ_FUNCT3;
                    wdata_q  <= al_wdata;
                    wstrb_q  <= al_wstrb;
                    if (req_illegal || req_misaligned) begin
                        resp_err_q   <= req_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                        resp_rdata_q <= '0;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else if (REQ_WRITE) begin
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_WADDR;
                    end else begin
                        arvalid_q <= 1'b1;
                        state_q   <= S_RADDR;
                    end
                end
                S_RADDR: if (M_AXI_ARREADY) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= S_RDATA;
                end
                S_RDATA: if (M_AXI_RVALID) begin
                    rready_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_DONE;
                    if (M_AXI_RRESP[RESP_SLVERR_BIT]) begin
                        resp_err_q   <= ERR_BUS;
                        resp_rdata_q <= '0;
                    end else begin
                        resp_err_q   <= ERR_OK;
                        resp_rdata_q <= al_rdata;
                    end
                end
                S_WADDR: begin
                    if (M_AXI_AWREADY) awvalid_q <= 1'b0;
                    if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WRESP;
                    end
                end
                S_WRESP: if (M_AXI_BVALID) begin
                    bready_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                    resp_err_q   <= M_AXI_BRESP[RESP_SLVERR_BIT] ? ERR_BUS : ERR_OK;
                    state_q      <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: 32- and 64-bit instances in lockstep
// against a byte-level memory model and a delay-programmable AXI slave.
module tb_data_mem_access;

    typedef struct {
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wd;
        bit [63:0] rword;
        bit [1:0]  resp;
        int        ar_d, r_d, aw_d, w_d, b_d;
    } txn_t;

    typedef struct {
        int        lat;
        bit        tmo, wait0, extra_pulse, unstable, bad_const, lock_diff;
        bit [31:0] rd32, rd64;
        bit [1:0]  er32, er64;
        bit        ar_seen, aw_seen, w_seen;
        bit [31:0] araddr, awaddr;
        bit [2:0]  arsize, awsize;
        bit [31:0] wd32;
        bit [63:0] wd64;
        bit [3:0]  ws32;
        bit [7:0]  ws64;
        int        aw_last, w_last;
    } obs_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_write = 0;
    logic [2:0]  req_f3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        arready = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
    logic [1:0]  rresp = 0, bresp = 0;
    logic [63:0] rword_g = 0;
    logic [31:0] cur_addr = 0;
    logic [31:0] rdata32;
    logic [63:0] rdata64;

    assign rdata64 = rword_g;
    assign rdata32 = cur_addr[2] ? rword_g[63:32] : rword_g[31:0];

    logic        wait32, rv32, awv32, wv32, wl32, br32, arv32, rr32;
    logic [31:0] rd32, awa32, ara32, wd32;
    logic [1:0]  er32, awb32, arb32;
    logic [0:0]  awid32, arid32;
    logic [7:0]  awl32, arl32;
    logic [2:0]  aws32, ars32;
    logic [3:0]  ws32;

    logic        wait64, rv64, awv64, wv64, wl64, br64, arv64, rr64;
    logic [31:0] rd64, awa64, ara64;
    logic [63:0] wd64;
    logic [1:0]  er64, awb64, arb64;
    logic [0:0]  awid64, arid64;
    logic [7:0]  awl64, arl64;
    logic [2:0]  aws64, ars64;
    logic [7:0]  ws64;

    wire [40:0] live32 = {wait32, rv32, awv32, wv32, br32, arv32, rr32, er32, rd32};
    wire [40:0] live64 = {wait64, rv64, awv64, wv64, br64, arv64, rr64, er64, rd64};

    data_mem_access #(.C_M_AXI_DATA_WIDTH(32)) u32 (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_WRITE(req_write), .REQ_FUNCT3(req_f3),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .MEM_WAIT(wait32), .RESP_VALID(rv32), .RESP_RDATA(rd32), .RESP_ERR(er32),
        .M_AXI_AWID(awid32), .M_AXI_AWADDR(awa32), .M_AXI_AWLEN(awl32),
        .M_AXI_AWSIZE(aws32), .M_AXI_AWBURST(awb32), .M_AXI_AWVALID(awv32),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wd32), .M_AXI_WSTRB(ws32), .M_AXI_WLAST(wl32),
        .M_AXI_WVALID(wv32), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(br32),
        .M_AXI_ARID(arid32), .M_AXI_ARADDR(ara32), .M_AXI_ARLEN(arl32),
        .M_AXI_ARSIZE(ars32), .M_AXI_ARBURST(arb32), .M_AXI_ARVALID(arv32),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata32), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rvalid),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rr32)
    );

    data_mem_access #(.C_M_AXI_DATA_WIDTH(64)) u64 (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_WRITE(req_write), .REQ_FUNCT3(req_f3),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .MEM_WAIT(wait64), .RESP_VALID(rv64), .RESP_RDATA(rd64), .RESP_ERR(er64),
        .M_AXI_AWID(awid64), .M_AXI_AWADDR(awa64), .M_AXI_AWLEN(awl64),
        .M_AXI_AWSIZE(aws64), .M_AXI_AWBURST(awb64), .M_AXI_AWVALID(awv64),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wd64), .M_AXI_WSTRB(ws64), .M_AXI_WLAST(wl64),
        .M_AXI_WVALID(wv64), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(br64),
        .M_AXI_ARID(arid64), .M_AXI_ARADDR(ara64), .M_AXI_ARLEN(arl64),
        .M_AXI_ARSIZE(ars64), .M_AXI_ARBURST(arb64), .M_AXI_ARVALID(arv64),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata64), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rvalid),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rr64)
    );

    // ---------------- reference model ----------------
    function automatic int m_size(txn_t t);
        return 1 << t.f3[1:0];
    endfunction

    function automatic bit [1:0] m_err(txn_t t);
        bit legal;
        if (t.wr) legal = (t.f3 <= 2);
        else      legal = (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 2'b11;
        if ((t.addr % m_size(t)) != 0) return 2'b01;
        if (t.resp[1]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit [31:0] m_rdata(txn_t t);
        bit [63:0] v = 0;
        int sz = m_size(t);
        int off = int'(t.addr[2:0]);
        if (t.wr || m_err(t) != 0) return 0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = t.rword[8*(off+i) +: 8];
        if (!t.f3[2] && sz < 4 && v[8*sz-1])
            for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v[31:0];
    endfunction

    function automatic bit [63:0] m_wdata(txn_t t, int nb);
        bit [63:0] v = 0;
        int sz = m_size(t);
        for (int i = 0; i < nb; i++) v[8*i +: 8] = t.wd[8*(i % sz) +: 8];
        return v;
    endfunction

    function automatic bit [7:0] m_wstrb(txn_t t, int nb);
        bit [7:0] v = 0;
        int sz = m_size(t);
        int l = int'(t.addr % nb);
        for (int i = 0; i < nb; i++) v[i] = (i >= l) && (i < l + sz);
        return v;
    endfunction

    function automatic int m_lat(txn_t t);
        bit [1:0] e = m_err(t);
        if (e == 2'b11 || e == 2'b01) return 1;
        if (!t.wr) return 3 + t.ar_d + t.r_d;
        return 3 + (t.aw_d > t.w_d ? t.aw_d : t.w_d) + t.b_d;
    endfunction

    // ---------------- request driver + AXI slave ----------------
    task automatic run_txn(input txn_t t, output obs_t o);
        int  ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
        bit  ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
        bit  ar_p = 0, r_p = 0, aw_p = 0, w_p = 0, b_p = 0;
        o = '{default: 0};
        @(negedge clk);
        cur_addr  = t.addr;
        rword_g   = t.rword;
        rresp     = t.resp;
        bresp     = t.resp;
        req_write = t.wr;
        req_f3    = t.f3;
        req_addr  = t.addr;
        req_wdata = t.wd;
        req_valid = 1;
        #1 o.wait0 = wait32 && wait64;
        o.tmo = 1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            ar_hs |= ar_p; r_hs |= r_p; aw_hs |= aw_p; w_hs |= w_p; b_hs |= b_p;
            ar_p = 0; r_p = 0; aw_p = 0; w_p = 0; b_p = 0;
            if (live32[40:34] !== live64[40:34]) o.lock_diff = 1;
            if ((arv32 && (arl32 != 0 || arb32 != 2'b01 || arid32 != 0)) ||
                (awv32 && (awl32 != 0 || awb32 != 2'b01 || awid32 != 0)) ||
                (arv64 && (arl64 != 0 || arb64 != 2'b01 || arid64 != 0)) ||
                (awv64 && (awl64 != 0 || awb64 != 2'b01 || awid64 != 0)) ||
                (wv32 && !wl32) || (wv64 && !wl64))
                o.bad_const = 1;
            if (rv32 || rv64) begin
                o.lat = n; o.tmo = 0;
                o.rd32 = rd32; o.rd64 = rd64; o.er32 = er32; o.er64 = er64;
                break;
            end
            if (arv32) begin
                if (o.ar_seen && (ara32 != o.araddr || ars32 != o.arsize)) o.unstable = 1;
                o.ar_seen = 1; o.araddr = ara32; o.arsize = ars32;
                arready = (ar_c >= t.ar_d); ar_p = arready; ar_c++;
            end else arready = 0;
            rvalid = ar_hs && !r_hs && (r_c >= t.r_d);
            if (ar_hs) r_c++;
            r_p = rvalid && rr32;
            if (awv32) begin
                if (o.aw_seen && (awa32 != o.awaddr || aws32 != o.awsize)) o.unstable = 1;
                o.aw_seen = 1; o.awaddr = awa32; o.awsize = aws32; o.aw_last = n;
                awready = (aw_c >= t.aw_d); aw_p = awready; aw_c++;
            end else awready = 0;
            if (wv32) begin
                if (o.w_seen && (wd32 != o.wd32 || wd64 != o.wd64)) o.unstable = 1;
                o.w_seen = 1; o.wd32 = wd32; o.wd64 = wd64;
                o.ws32 = ws32; o.ws64 = ws64; o.w_last = n;
                wready = (w_c >= t.w_d); w_p = wready; w_c++;
            end else wready = 0;
            bvalid = aw_hs && w_hs && !b_hs && (b_c >= t.b_d);
            if (aw_hs && w_hs) b_c++;
            b_p = bvalid && br32;
        end
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        req_valid = 0;
        if (!o.tmo) begin
            @(negedge clk);
            o.extra_pulse = rv32 || rv64;
        end else begin
            rst = 1;
            @(negedge clk);
            rst = 0;
        end
    endtask

    function automatic txn_t mk(bit wr, bit [2:0] f3, bit [31:0] a, bit [31:0] wd,
                                bit [63:0] rw, bit [1:0] resp);
        txn_t t;
        t.wr = wr; t.f3 = f3; t.addr = a; t.wd = wd; t.rword = rw; t.resp = resp;
        t.ar_d = 0; t.r_d = 0; t.aw_d = 0; t.w_d = 0; t.b_d = 0;
        return t;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if (live32 !== '0) begin
            n_bad++; $display("FAIL reset32: got %h want 0", live32);
        end
        n_cmp++;
        if (live64 !== '0) begin
            n_bad++; $display("FAIL reset64: got %h want 0", live64);
        end
        rst = 0;
    endtask

    task automatic test_lw_basic;
        obs_t o;
        txn_t t = mk(0, 3'd2, 32'h1000, 0, 64'h5555_AAAA_DEAD_BEEF, 2'b00);
        run_txn(t, o);
        n_cmp++;
        if (o.tmo !== 0 || o.lat !== 3) begin
            n_bad++; $display("FAIL lw_latency: got %0d (tmo %0d) want 3", o.lat, o.tmo);
        end
        n_cmp++;
        if (o.rd32 !== 32'hDEADBEEF || o.rd64 !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL lw_data: got %h/%h want deadbeef", o.rd32, o.rd64);
        end
        n_cmp++;
        if (o.araddr !== 32'h1000 || o.arsize !== 3'd2) begin
            n_bad++; $display("FAIL lw_ar: got %h/%0d want 1000/2", o.araddr, o.arsize);
        end
        n_cmp++;
        if (o.er32 !== 2'b00 || o.er64 !== 2'b00 || o.aw_seen !== 0) begin
            n_bad++; $display("FAIL lw_err: got %b/%b aw %0d want 00/00 aw 0",
                              o.er32, o.er64, o.aw_seen);
        end
        n_cmp++;
        if (o.wait0 !== 1 || o.extra_pulse !== 0) begin
            n_bad++; $display("FAIL lw_wait_pulse: got wait0 %0d extra %0d want 1 0",
                              o.wait0, o.extra_pulse);
        end
    endtask

    task automatic test_extend;
        obs_t o;
        run_txn(mk(0, 3'd0, 32'h1003, 0, 64'h0000_0000_80FF_FFFF, 2'b00), o);
        n_cmp++;
        if (o.rd32 !== 32'hFFFFFF80 || o.rd64 !== 32'hFFFFFF80) begin
            n_bad++; $display("FAIL lb_sext: got %h/%h want ffffff80", o.rd32, o.rd64);
        end
        run_txn(mk(0, 3'd4, 32'h1003, 0, 64'h0000_0000_80FF_FFFF, 2'b00), o);
        n_cmp++;
        if (o.rd32 !== 32'h00000080 || o.rd64 !== 32'h00000080) begin
            n_bad++; $display("FAIL lbu_zext: got %h/%h want 00000080", o.rd32, o.rd64);
        end
        run_txn(mk(0, 3'd1, 32'h1006, 0, 64'h1234_5678_0000_0000, 2'b00), o);
        n_cmp++;
        if (o.rd32 !== 32'h00001234 || o.rd64 !== 32'h00001234) begin
            n_bad++; $display("FAIL lh_hi_lane: got %h/%h want 00001234", o.rd32, o.rd64);
        end
    endtask

    task automatic test_store_split;
        obs_t o;
        txn_t t = mk(1, 3'd1, 32'h2002, 32'h0000ABCD, 0, 2'b00);
        t.w_d = 0; t.aw_d = 3;
        run_txn(t, o);
        n_cmp++;
        if (o.wd32 !== 32'hABCDABCD || o.ws32 !== 4'hC) begin
            n_bad++; $display("FAIL sh_w32: got %h/%h want abcdabcd/c", o.wd32, o.ws32);
        end
        n_cmp++;
        if (o.wd64 !== 64'hABCDABCD_ABCDABCD || o.ws64 !== 8'h0C) begin
            n_bad++; $display("FAIL sh_w64: got %h/%h want abcdabcdabcdabcd/0c",
                              o.wd64, o.ws64);
        end
        n_cmp++;
        if (o.awaddr !== 32'h2002 || o.awsize !== 3'd1) begin
            n_bad++; $display("FAIL sh_aw: got %h/%0d want 2002/1", o.awaddr, o.awsize);
        end
        n_cmp++;
        if (o.w_last !== 1 || o.aw_last !== 4) begin
            n_bad++; $display("FAIL sh_valid_drop: got w %0d aw %0d want 1 4",
                              o.w_last, o.aw_last);
        end
        n_cmp++;
        if (o.tmo !== 0 || o.lat !== 6 || o.extra_pulse !== 0 || o.ar_seen !== 0) begin
            n_bad++; $display("FAIL sh_resp: got lat %0d extra %0d ar %0d want 6 0 0",
                              o.lat, o.extra_pulse, o.ar_seen);
        end
    endtask

    task automatic test_errors;
        obs_t o;
        run_txn(mk(0, 3'd2, 32'h1002, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00), o);
        n_cmp++;
        if (o.er32 !== 2'b01 || o.er64 !== 2'b01 || o.lat !== 1) begin
            n_bad++; $display("FAIL misalign: got %b/%b lat %0d want 01 lat 1",
                              o.er32, o.er64, o.lat);
        end
        n_cmp++;
        if (o.ar_seen !== 0 || o.aw_seen !== 0 || o.rd32 !== 0) begin
            n_bad++; $display("FAIL misalign_bus: got ar %0d aw %0d rd %h want 0 0 0",
                              o.ar_seen, o.aw_seen, o.rd32);
        end
        run_txn(mk(0, 3'd3, 32'h1000, 0, 0, 2'b00), o);
        n_cmp++;
        if (o.er32 !== 2'b11 || o.er64 !== 2'b11 || o.lat !== 1 || o.ar_seen !== 0) begin
            n_bad++; $display("FAIL illegal_ld: got %b/%b lat %0d want 11 lat 1",
                              o.er32, o.er64, o.lat);
        end
        run_txn(mk(1, 3'd4, 32'h1000, 0, 0, 2'b00), o);
        n_cmp++;
        if (o.er32 !== 2'b11 || o.aw_seen !== 0) begin
            n_bad++; $display("FAIL illegal_st: got %b aw %0d want 11 aw 0",
                              o.er32, o.aw_seen);
        end
    endtask

    task automatic test_bus_err;
        obs_t o;
        run_txn(mk(1, 3'd2, 32'h4000, 32'h1122_3344, 0, 2'b10), o);
        n_cmp++;
        if (o.er32 !== 2'b10 || o.er64 !== 2'b10) begin
            n_bad++; $display("FAIL sw_slverr: got %b/%b want 10", o.er32, o.er64);
        end
        run_txn(mk(0, 3'd2, 32'h4000, 0, 64'hCAFE_F00D_CAFE_F00D, 2'b11), o);
        n_cmp++;
        if (o.er32 !== 2'b10 || o.rd32 !== 0 || o.rd64 !== 0) begin
            n_bad++; $display("FAIL lw_decerr: got %b rd %h/%h want 10 rd 0",
                              o.er32, o.rd32, o.rd64);
        end
    endtask

    task automatic test_reset_midtxn;
        obs_t o;
        @(negedge clk);
        cur_addr = 32'h3000; rword_g = 64'h0;
        req_write = 0; req_f3 = 3'd2; req_addr = 32'h3000; req_valid = 1;
        @(negedge clk);
        arready = 1;
        @(negedge clk);
        arready = 0;
        n_cmp++;
        if (rr32 !== 1 || rr64 !== 1) begin
            n_bad++; $display("FAIL pre_rst_rready: got %0d/%0d want 1", rr32, rr64);
        end
        #1 rst = 1;
        #1;
        n_cmp++;
        if (live32 !== '0 || live64 !== '0) begin
            n_bad++; $display("FAIL mid_rst_outs: got %h/%h want 0", live32, live64);
        end
        @(negedge clk);
        req_valid = 0; rst = 0;
        run_txn(mk(0, 3'd2, 32'h3004, 0, 64'h0BAD_F00D_0000_0000, 2'b00), o);
        n_cmp++;
        if (o.lat !== 3 || o.rd32 !== 32'h0BADF00D || o.rd64 !== 32'h0BADF00D) begin
            n_bad++; $display("FAIL post_rst_lw: got lat %0d rd %h/%h want 3 0badf00d",
                              o.lat, o.rd32, o.rd64);
        end
    endtask

    task automatic test_random;
        obs_t o;
        txn_t t;
        bit [2:0] f3s[8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd7};
        for (int k = 0; k < 60; k++) begin
            t.wr = $urandom_range(1);
            t.f3 = f3s[$urandom_range(7)];
            t.addr = $urandom;
            if ($urandom_range(3) != 0) t.addr = t.addr & ~(32'(m_size(t)) - 1);
            t.wd = $urandom;
            t.rword = {$urandom, $urandom};
            t.resp = ($urandom_range(5) == 0) ? 2'(2 + $urandom_range(1))
                                              : 2'($urandom_range(1));
            t.ar_d = $urandom_range(3); t.r_d = $urandom_range(3);
            t.aw_d = $urandom_range(3); t.w_d = $urandom_range(3);
            t.b_d = $urandom_range(3);
            run_txn(t, o);
            n_cmp++;
            if (o.tmo !== 0 || o.lat !== m_lat(t)) begin
                n_bad++; $display("FAIL rnd%0d_lat: got %0d tmo %0d want %0d",
                                  k, o.lat, o.tmo, m_lat(t));
            end
            n_cmp++;
            if (o.er32 !== m_err(t) || o.er64 !== m_err(t)) begin
                n_bad++; $display("FAIL rnd%0d_err: got %b/%b want %b",
                                  k, o.er32, o.er64, m_err(t));
            end
            n_cmp++;
            if (o.rd32 !== m_rdata(t) || o.rd64 !== m_rdata(t)) begin
                n_bad++; $display("FAIL rnd%0d_rdata: got %h/%h want %h",
                                  k, o.rd32, o.rd64, m_rdata(t));
            end
            n_cmp++;
            if (o.ar_seen !== (!t.wr && m_err(t) inside {2'b00, 2'b10}) ||
                o.aw_seen !== (t.wr && m_err(t) inside {2'b00, 2'b10})) begin
                n_bad++; $display("FAIL rnd%0d_bus: got ar %0d aw %0d", k,
                                  o.ar_seen, o.aw_seen);
            end
            n_cmp++;
            if (o.unstable || o.bad_const || o.lock_diff || o.extra_pulse) begin
                n_bad++; $display("FAIL rnd%0d_proto: got unst %0d const %0d lock %0d pulse %0d want 0",
                                  k, o.unstable, o.bad_const, o.lock_diff, o.extra_pulse);
            end
            if (o.ar_seen) begin
                n_cmp++;
                if (o.araddr !== t.addr || o.arsize !== {1'b0, t.f3[1:0]}) begin
                    n_bad++; $display("FAIL rnd%0d_ar: got %h/%0d want %h/%0d",
                                      k, o.araddr, o.arsize, t.addr, t.f3[1:0]);
                end
            end
            if (o.aw_seen) begin
                n_cmp++;
                if (o.awaddr !== t.addr || o.awsize !== {1'b0, t.f3[1:0]}) begin
                    n_bad++; $display("FAIL rnd%0d_aw: got %h/%0d want %h/%0d",
                                      k, o.awaddr, o.awsize, t.addr, t.f3[1:0]);
                end
                n_cmp++;
                if (o.wd32 !== m_wdata(t, 4)[31:0] || o.wd64 !== m_wdata(t, 8) ||
                    o.ws32 !== m_wstrb(t, 4)[3:0] || o.ws64 !== m_wstrb(t, 8)) begin
                    n_bad++; $display("FAIL rnd%0d_w: got %h %h %h %h want %h %h %h %h",
                                      k, o.wd32, o.ws32, o.wd64, o.ws64,
                                      m_wdata(t, 4), m_wstrb(t, 4),
                                      m_wdata(t, 8), m_wstrb(t, 8));
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_lw_basic;
        test_extend;
        test_store_split;
        test_errors;
        test_bus_err;
        test_reset_midtxn;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_access.md
Name: data_mem_access

Overview:
Load/store unit for the RV32I pipeline core. It turns one memory request from the memory stage into a single-beat AXI4 read or write on the data master port. It handles byte, halfword and word accesses, including lane steering, strobes and sign/zero extension, for bus widths of 32 or 64 bits. It drives MEM_WAIT into the core-wide stall and returns load data or an error code.

Parameters:
C_M_AXI_THREAD_ID_WIDTH, 1, width of AWID/ARID; always driven 0.
C_M_AXI_ADDR_WIDTH, 32, AXI address width; must be ≥ 32.
C_M_AXI_DATA_WIDTH, 32, AXI data width; legal values are 32 and 64.

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active high
REQ_VALID  in  1  memory request present; held stable while MEM_WAIT=1
REQ_WRITE  in  1  1=store, 0=load
REQ_FUNCT3  in  3  RV32I funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
REQ_ADDR  in  32  byte address
REQ_WDATA  in  32  store data, right-aligned
MEM_WAIT  out  1  stall request to the core
RESP_VALID  out  1  one-cycle completion pulse
RESP_RDATA  out  32  extended load data; 0 for stores and errors
RESP_ERR  out  2  00 ok, 01 misaligned, 10 bus error (xRESP[1]=1), 11 illegal funct3
M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  ID/ADDR/8/3/2/1  write address
M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB/WLAST/WVALID  out  DW/DW/8/1/1  write data
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2;  M_AXI_BVALID  in  1;  M_AXI_BREADY  out  1
M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  ID/ADDR/8/3/2/1  read address
M_AXI_ARREADY  in  1
M_AXI_RDATA  in  DW;  M_AXI_RRESP  in  2;  M_AXI_RLAST  in  1;  M_AXI_RVALID  in  1;  M_AXI_RREADY  out  1

Behaviour:
- Reset: state IDLE; all VALID/READY outputs 0; RESP_VALID 0; RESP_RDATA 0; RESP_ERR 00. Reset mid-transaction abandons the transaction immediately. The interconnect is reset by the same RST.
- Constant fields: AxLEN=0, AxBURST=01 (INCR), AxID=0, WLAST=1 whenever WVALID=1. AxSIZE=REQ_FUNCT3[1:0]. AxADDR=REQ_ADDR zero-extended, registered when the request is accepted.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
- Lane select: L = addr[log2(DW/8)-1:0].
- WDATA = store data replicated across the bus (byte ×DW/8, half ×DW/16, word ×DW/32).
- WSTRB = size mask (0x1, 0x3 or 0xF) shifted left by L.
- Load extraction: shift RDATA right by 8·L, take the low 8/16/32 bits, then sign-extend (funct3 0, 1) or zero-extend (funct3 4, 5).
- States: IDLE, RADDR, RDATA, WADDR, WRESP, DONE.
- IDLE, REQ_VALID=0: stay in IDLE, MEM_WAIT=0.
- IDLE, REQ_VALID=1: MEM_WAIT=1 combinationally in the same cycle.
  - Illegal funct3 or misaligned: go to DONE with the matching error code; no bus activity.
  - Illegal funct3 for stores is any funct3 other than 0–2.
  - Otherwise load → RADDR, store → WADDR.
- RADDR: ARVALID=1 until ARREADY, then → RDATA.
- RDATA: RREADY=1. On RVALID: capture the extended data and RRESP, then → DONE.
- WADDR: AWVALID and WVALID are both raised on entry and each drops independently on its own handshake. Simultaneous AW and W handshakes in one cycle are legal. When both are done → WRESP.
- WRESP: BREADY=1. On BVALID: capture BRESP, then → DONE.
- DONE: MEM_WAIT=0 and RESP_VALID=1 for exactly one cycle, then → IDLE.
  - REQ_VALID is ignored in DONE; the pipeline advances on this edge.
  - A new request is sampled in IDLE on the following cycle.
- Bus error reporting: RESP_RDATA=0; RESP_ERR=10 if RRESP[1] or BRESP[1] is set.
- VALID, once asserted, is held until its handshake; the address and data it carries do not change while held.
- Minimum latency: a load takes 3 cycles from IDLE to RESP_VALID when ARREADY and RVALID arrive at the earliest; an error response takes 1 cycle.
- At most one outstanding transaction.

Decomposition:
- Shared package (core_pkg):
  - funct3 encodings: LB, LH, LW, LBU, LHU, SB, SH, SW
  - RESP_ERR codes
  - state encoding
  - AXI constants: BURST_INCR, RESP_SLVERR bit
- One combinational sub-module, mem_lane_align (parametrised by DW), for WDATA/WSTRB generation and load extraction/extension. The FSM stays in data_mem_access.

Test Plan:
- LW at 0x1000, DW=32, ARREADY and RVALID with RDATA=0xDEADBEEF on the first cycles → ARADDR=0x1000, ARSIZE=2, RESP_RDATA=0xDEADBEEF, ERR=00, RESP_VALID 3 cycles after REQ_VALID.
- LB vs LBU at 0x1003, RDATA=0x80FF_FFFF → 0xFFFFFF80 vs 0x00000080; with DW=64, LH at 0x1006 and RDATA=0x1234_5678_0000_0000 → 0x00001234.
- SH of 0xABCD at 0x2002, DW=32 → WDATA=0xABCDABCD, WSTRB=0xC, AWSIZE=1; WREADY 3 cycles before AWREADY → each VALID drops on its own handshake, single RESP_VALID after BVALID.
- LW at 0x1002 → RESP_ERR=01 after 1 cycle, ARVALID and AWVALID never asserted; funct3=3 → RESP_ERR=11.
- SW with BRESP=10 → RESP_ERR=10; LW with RRESP=11 → RESP_ERR=10, RESP_RDATA=0.
- RST asserted while in RDATA with ARREADY held low → all outputs 0 in the same cycle; a request presented after reset completes normally.
